sram_bist_seq: RTL and testbench

- Upstream command sequencer for the SRAM controller. It drives the controller's 32-bit register interface (enable, send, sta_addr, tim_cfg, op_cfg) and consumes its status, outp_data and outp_addr.
- Runs an autonomous fill-then-readback test over the full address range for up to four data patterns, then reports pass/fail, error count and the first failing location.
- Sits between the bus register block and the controller, so a single start bit runs a complete memory test without software stepping.

---
 rtl/sram_test_pkg.sv | 36 +++
 rtl/sram_bist_seq_if.sv | 23 ++
 rtl/sram_bist_pat.sv | 25 ++
 rtl/sram_bist_seq.sv | 205 ++++++++++++++++++++
 tb/tb_sram_bist_seq.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_test_pkg.sv
// Shared types and constants for the SRAM BIST sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_test_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_ARM,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_CHECK,
        S_DONE
    } seq_state_t;

    // Controller status[7:0] one-hot state codes
    localparam logic [7:0] ST_CONFIG = 8'h01;
    localparam logic [7:0] ST_IDLE   = 8'h02;
    localparam logic [7:0] ST_READ   = 8'h04;
    localparam logic [7:0] ST_WRITE  = 8'h08;
    localparam logic [7:0] ST_UPDATE = 8'h10;

    localparam int EN_ENA_BIT = 0;
    localparam int EN_CMD_BIT = 1;
    localparam logic [31:0] EN_WRITE = 32'(1) << EN_ENA_BIT;
    localparam logic [31:0] EN_READ  = EN_WRITE | (32'(1) << EN_CMD_BIT);

    // Increment addressing, no cycling
    localparam logic [31:0] OP_LINEAR = 32'h0;

    // Entry 0 is applied first
    localparam logic [3:0][7:0] PAT_TABLE = {8'hFF, 8'h00, 8'hAA, 8'h55};

endpackage

// File: rtl/sram_bist_seq_if.sv
// Register-level link between the BIST sequencer and the SRAM controller.
// Latency: n/a (wires only).
// Backpressure: controller progress is reported through status.
interface sram_bist_seq_if;
    logic [31:0] enable;
    logic [31:0] send;
    logic [31:0] sta_addr;
    logic [31:0] tim_cfg;
    logic [31:0] op_cfg;
    logic [31:0] status;
    logic [31:0] outp_data;
    logic [31:0] outp_addr;

    modport master (
        output enable, send, sta_addr, tim_cfg, op_cfg,
        input  status, outp_data, outp_addr
    );

    modport slave (
        input  enable, send, sta_addr, tim_cfg, op_cfg,
        output status, outp_data, outp_addr
    );
endinterface

// File: rtl/sram_bist_pat.sv
// Maps a pattern index to a DATA_W test word and flags the final pattern.
// Latency: combinational.
// Backpressure: none.
module sram_bist_pat
    import sram_test_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_PAT = 4
) (
    input  logic [1:0]        pat_idx,
    output logic [DATA_W-1:0] pattern,
    output logic              last_pat
);

    logic [7:0] pat_byte;

    assign pat_byte = PAT_TABLE[pat_idx];
    assign last_pat = (pat_idx == 2'(NUM_PAT - 1));

    // Widths above 8 repeat the byte; narrower widths keep its low bits
    for (genvar g = 0; g < DATA_W; g++) begin : g_bit
        assign pattern[g] = pat_byte[g % 8];
    end

endmodule

// File: rtl/sram_bist_seq.sv
// Autonomous fill/readback memory test driving the SRAM controller registers.
// Latency: per read 1 issue + controller turnaround + 1 check cycle.
// Backpressure: each command waits for controller IDLE, bounded by TO_CYC.
module sram_bist_seq
    import sram_test_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 1024,
    parameter int NUM_PAT = 4,
    parameter int TO_CYC  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    sram_bist_seq_if.master   ctrl
);

    localparam int TO_W = $clog2(TO_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    seq_state_t        state;
    logic              tog;
    logic [1:0]        pat_idx;
    logic [ADDR_W-1:0] addr;
    logic              seen;
    logic              cfg_hit;
    logic [TO_W-1:0]   to_cnt;

    logic [DATA_W-1:0] pattern;
    logic              last_pat;
    logic [7:0]        st;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              mismatch;
    logic              wait_state;
    logic              to_hit;
    logic              unused_bits;

    sram_bist_pat #(
        .DATA_W  (DATA_W),
        .NUM_PAT (NUM_PAT)
    ) u_pat (
        .pat_idx  (pat_idx),
        .pattern  (pattern),
        .last_pat (last_pat)
    );

    assign st       = ctrl.status[7:0];
    assign rd_data  = ctrl.outp_data[DATA_W-1:0];
    assign rd_addr  = ctrl.outp_addr[ADDR_W-1:0];
    assign mismatch = (rd_data != pattern) || (rd_addr != addr);

    assign wait_state = (state == S_CFG) || (state == S_ARM) ||
                        (state == S_WR_WAIT) || (state == S_RD_WAIT);
    assign to_hit     = wait_state && (to_cnt == TO_W'(TO_CYC - 1));

    assign unused_bits = ^{ctrl.status[31:8], ctrl.outp_data[31:DATA_W],
                           ctrl.outp_addr[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            fail_addr     <= '0;
            fail_data     <= '0;
            ctrl.enable   <= '0;
            ctrl.send     <= '0;
            ctrl.sta_addr <= '0;
            ctrl.tim_cfg  <= '0;
            ctrl.op_cfg   <= '0;
            tog           <= 1'b0;
            pat_idx       <= '0;
            addr          <= '0;
            seen          <= 1'b0;
            cfg_hit       <= 1'b0;
            to_cnt        <= '0;
        end else begin
            if (wait_state) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_cnt       <= '0;
                        fail_addr     <= '0;
                        fail_data     <= '0;
                        timeout       <= 1'b0;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        ctrl.enable   <= '0;
                        ctrl.sta_addr <= '0;
                        ctrl.op_cfg   <= OP_LINEAR;
                        ctrl.tim_cfg  <= 32'(DEPTH - 1);
                        pat_idx       <= '0;
                        cfg_hit       <= 1'b0;
                        to_cnt        <= '0;
                        state         <= S_CFG;
                    end
                end
                // Controller must settle in CONFIG for two cycles before arming
                S_CFG: begin
                    cfg_hit <= (st == ST_CONFIG);
                    if (cfg_hit && st == ST_CONFIG) begin
                        ctrl.enable <= EN_WRITE;
                        to_cnt      <= '0;
                        state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (st == ST_IDLE) begin
                        state <= S_WR_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    tog         <= ~tog;
                    ctrl.send   <= {~tog, {(31 - DATA_W){1'b0}}, pattern};
                    ctrl.enable <= EN_WRITE;
                    seen        <= 1'b0;
                    to_cnt      <= '0;
                    state       <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (st != ST_IDLE) begin
                        seen <= 1'b1;
                    end else if (seen) begin
                        addr  <= '0;
                        state <= S_RD_ISSUE;
                    end
                end
                // tog keeps send changing even if the same address is reissued
                S_RD_ISSUE: begin
                    tog         <= ~tog;
                    ctrl.send   <= {~tog, {(31 - ADDR_W){1'b0}}, addr};
                    ctrl.enable <= EN_READ;
                    seen        <= 1'b0;
                    to_cnt      <= '0;
                    state       <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (st != ST_IDLE) begin
                        seen <= 1'b1;
                    end else if (seen) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != 16'hFFFF) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                        if (err_cnt == '0) begin
                            fail_addr <= addr;
                            fail_data <= rd_data;
                        end
                    end
                    if (addr == LAST_ADDR) begin
                        if (last_pat) begin
                            state <= S_DONE;
                        end else begin
                            pat_idx     <= pat_idx + 2'd1;
                            ctrl.enable <= EN_WRITE;
                            state       <= S_WR_ISSUE;
                        end
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_RD_ISSUE;
                    end
                end
                S_DONE: begin
                    ctrl.enable <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= (err_cnt == '0) && !timeout;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // A stuck wait overrides whatever the state would have done
            if (to_hit) begin
                ctrl.enable <= '0;
                timeout     <= 1'b1;
                pass        <= 1'b0;
                done        <= 1'b1;
                busy        <= 1'b0;
                state       <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_seq.sv
// Directed bench: behavioural SRAM controller with fault injection around sram_bist_seq.
module tb_sram_bist_seq;
    import sram_test_pkg::*;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 256;
    localparam int NUM_PAT   = 4;
    localparam int TO_CYC    = 512;
    localparam int RUN_BOUND = 20000;
    localparam logic [ADDR_W-1:0] STUCK_ADDR = 8'hA7;
    localparam int RESET_AT  = 'h80;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy, done, pass, timeout;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;

    int checks = 0;
    int errors = 0;

    sram_bist_seq_if ctrl ();

    sram_bist_seq #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .NUM_PAT(NUM_PAT), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .fail_addr(fail_addr), .fail_data(fail_data),
        .ctrl(ctrl)
    );

    always #5 clk = ~clk;

    // Behavioural controller plus SRAM
    typedef enum logic [2:0] {C_CONFIG, C_IDLE, C_READ, C_WRITE, C_UPDATE} ctl_state_t;
    ctl_state_t        cst = C_CONFIG;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [31:0]       last_send = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] exp_rd_addr = '0;
    logic stuck_en, hang_rd, clr_stats;
    int wr_cnt = 0, rd_cnt = 0, tog_err = 0, seq_err = 0;

    function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = mem[a];
        if (stuck_en && a == STUCK_ADDR) d[0] = 1'b1;
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] exp_pat(input int n);
        case (n % 4)
            0:       return 8'h55;
            1:       return 8'hAA;
            2:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        ctrl.status = 32'h0;
        case (cst)
            C_CONFIG: ctrl.status[7:0] = ST_CONFIG;
            C_IDLE:   ctrl.status[7:0] = ST_IDLE;
            C_READ:   ctrl.status[7:0] = ST_READ;
            C_WRITE:  ctrl.status[7:0] = ST_WRITE;
            default:  ctrl.status[7:0] = ST_UPDATE;
        endcase
    end

    always @(posedge clk) begin
        if (clr_stats) begin
            wr_cnt <= 0; rd_cnt <= 0; tog_err <= 0; seq_err <= 0; exp_rd_addr <= '0;
        end
        if (!ctrl.enable[0]) begin
            cst <= C_CONFIG;
        end else begin
            case (cst)
                C_CONFIG: begin
                    last_send <= ctrl.send;
                    cst <= C_IDLE;
                end
                C_IDLE: begin
                    if (ctrl.send != last_send) begin
                        last_send <= ctrl.send;
                        if (ctrl.send[31] == last_send[31]) tog_err <= tog_err + 1;
                        if (ctrl.enable[1]) begin
                            if (ctrl.send[ADDR_W-1:0] != exp_rd_addr) seq_err <= seq_err + 1;
                            exp_rd_addr <= ctrl.send[ADDR_W-1:0] + 1'b1;
                            rd_addr <= ctrl.send[ADDR_W-1:0];
                            rd_cnt  <= rd_cnt + 1;
                            cst     <= C_READ;
                        end else begin
                            if (ctrl.send[DATA_W-1:0] != exp_pat(wr_cnt)) seq_err <= seq_err + 1;
                            wr_data <= ctrl.send[DATA_W-1:0];
                            wr_cnt  <= wr_cnt + 1;
                            cst     <= C_WRITE;
                        end
                    end
                end
                C_READ: begin
                    if (!hang_rd) begin
                        ctrl.outp_data <= 32'(sram_rd(rd_addr));
                        ctrl.outp_addr <= 32'(rd_addr);
                        cst <= C_IDLE;
                    end
                end
                C_WRITE: begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= wr_data;
                    cst <= C_UPDATE;
                end
                default: cst <= C_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < RUN_BOUND; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if ({busy, done, pass, timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, pass, timeout}); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
        checks++; if (fail_addr !== '0) begin errors++; $display("FAIL reset_fail_addr: got %0h expected 0", fail_addr); end
        checks++; if (fail_data !== '0) begin errors++; $display("FAIL reset_fail_data: got %0h expected 0", fail_data); end
        checks++; if (ctrl.enable !== 32'h0) begin errors++; $display("FAIL reset_enable: got %0h expected 0", ctrl.enable); end
        checks++; if (ctrl.send !== 32'h0) begin errors++; $display("FAIL reset_send: got %0h expected 0", ctrl.send); end
        checks++; if ({ctrl.sta_addr, ctrl.tim_cfg, ctrl.op_cfg} !== 96'h0) begin errors++; $display("FAIL reset_cfg_regs: got %0h/%0h/%0h expected 0/0/0", ctrl.sta_addr, ctrl.tim_cfg, ctrl.op_cfg); end
    endtask

    task automatic test_good_memory();
        bit ok;
        int cyc;
        clear_stats();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_start: got %b expected 1", busy); end
        checks++; if (ctrl.tim_cfg !== 32'd255) begin errors++; $display("FAIL good_tim_cfg: got %0h expected ff", ctrl.tim_cfg); end
        checks++; if ({ctrl.sta_addr, ctrl.op_cfg} !== 64'h0) begin errors++; $display("FAIL good_sta_op: got %0h/%0h expected 0/0", ctrl.sta_addr, ctrl.op_cfg); end
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL good_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if ({pass, timeout, busy} !== 3'b100) begin errors++; $display("FAIL good_pass_to_busy: got %b expected 100", {pass, timeout, busy}); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL good_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (ctrl.enable !== 32'h0) begin errors++; $display("FAIL good_enable_off: got %0h expected 0", ctrl.enable); end
        checks++; if (wr_cnt !== 4) begin errors++; $display("FAIL good_writes: got %0d expected 4", wr_cnt); end
        checks++; if (rd_cnt !== 4 * DEPTH) begin errors++; $display("FAIL good_reads: got %0d expected %0d", rd_cnt, 4 * DEPTH); end
        checks++; if (tog_err !== 0) begin errors++; $display("FAIL good_send_toggle: got %0d repeats expected 0", tog_err); end
        checks++; if (seq_err !== 0) begin errors++; $display("FAIL good_cmd_sequence: got %0d bad commands expected 0", seq_err); end
    endtask

    task automatic test_stuck_bit();
        bit ok;
        int cyc;
        stuck_en = 1'b1;
        clear_stats();
        pulse_start();
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL stuck_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL stuck_err_cnt: got %0d expected 2", err_cnt); end
        checks++; if (fail_addr !== 8'hA7) begin errors++; $display("FAIL stuck_fail_addr: got %0h expected a7", fail_addr); end
        checks++; if (fail_data !== 8'hAB) begin errors++; $display("FAIL stuck_fail_data: got %0h expected ab", fail_data); end
        checks++; if ({pass, timeout} !== 2'b00) begin errors++; $display("FAIL stuck_pass_timeout: got %b expected 00", {pass, timeout}); end
        checks++; if (rd_cnt !== 4 * DEPTH) begin errors++; $display("FAIL stuck_reads: got %0d expected %0d", rd_cnt, 4 * DEPTH); end
        stuck_en = 1'b0;
    endtask

    task automatic test_hung_controller();
        bit ok;
        int cyc;
        hang_rd = 1'b1;
        clear_stats();
        pulse_start();
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL hung_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if ({timeout, pass, busy} !== 3'b100) begin errors++; $display("FAIL hung_flags: got %b expected 100", {timeout, pass, busy}); end
        checks++; if (ctrl.enable !== 32'h0) begin errors++; $display("FAIL hung_enable: got %0h expected 0", ctrl.enable); end
        checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL hung_reads: got %0d expected 1", rd_cnt); end
        checks++; if (cyc < TO_CYC || cyc > TO_CYC + 40) begin errors++; $display("FAIL hung_latency: got %0d cycles expected %0d..%0d", cyc, TO_CYC, TO_CYC + 40); end
        hang_rd = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        bit ok;
        bit hit;
        int cyc;
        clear_stats();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < RUN_BOUND && !hit; i++) begin
            if (rd_cnt == RESET_AT + 1) hit = 1'b1;
            else tick();
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_reach_addr: got %0d reads expected %0d", rd_cnt, RESET_AT + 1); end
        reset_n = 1'b0;
        tick();
        checks++; if ({busy, done, pass, timeout} !== 4'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {busy, done, pass, timeout}); end
        checks++; if ({err_cnt, fail_addr, fail_data} !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %0h expected 0", {err_cnt, fail_addr, fail_data}); end
        checks++; if ({ctrl.enable, ctrl.send, ctrl.tim_cfg} !== 96'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %0h/%0h/%0h expected 0/0/0", ctrl.enable, ctrl.send, ctrl.tim_cfg); end
        reset_n = 1'b1;
        tick();
        clear_stats();
        pulse_start();
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL rst_rerun_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if ({pass, timeout} !== 2'b10) begin errors++; $display("FAIL rst_rerun_pass: got %b expected 10", {pass, timeout}); end
        checks++; if (rd_cnt !== 4 * DEPTH || seq_err !== 0) begin errors++; $display("FAIL rst_rerun_reads: got %0d reads %0d bad expected %0d reads 0 bad", rd_cnt, seq_err, 4 * DEPTH); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        stuck_en = 1'b1;
        clear_stats();
        pulse_start();
        for (int i = 0; i < 50; i++) tick();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_ignored: got %b expected 1", busy); end
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if (wr_cnt !== 4 || rd_cnt !== 4 * DEPTH) begin errors++; $display("FAIL b2b_single_run: got %0d writes %0d reads expected 4 %0d", wr_cnt, rd_cnt, 4 * DEPTH); end
        checks++; if ({err_cnt, fail_addr, fail_data} !== {16'd2, 8'hA7, 8'hAB}) begin errors++; $display("FAIL b2b_first_result: got %0h expected 2a7ab", {err_cnt, fail_addr, fail_data}); end
        clear_stats();
        pulse_start();
        checks++; if ({err_cnt, fail_addr, fail_data} !== 32'h0) begin errors++; $display("FAIL b2b_restart_clear: got %0h expected 0", {err_cnt, fail_addr, fail_data}); end
        checks++; if ({done, pass, busy} !== 3'b001) begin errors++; $display("FAIL b2b_restart_flags: got %b expected 001", {done, pass, busy}); end
        wait_done(ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_second_done: got no done within %0d cycles, expected done", RUN_BOUND); end
        checks++; if ({err_cnt, fail_addr, fail_data} !== {16'd2, 8'hA7, 8'hAB}) begin errors++; $display("FAIL b2b_second_result: got %0h expected 2a7ab", {err_cnt, fail_addr, fail_data}); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL b2b_second_pass: got %b expected 0", pass); end
        stuck_en = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        stuck_en  = 1'b0;
        hang_rd   = 1'b0;
        clr_stats = 1'b0;
        test_reset();
        reset_n = 1'b1;
        tick();
        test_good_memory();
        test_stuck_bit();
        test_hung_controller();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
